// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding,
// FSM state encoding and the per-operation step count.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Number of CALC cycles needed to retire all operand bits.
   function automatic int calc_nstep(input int xlen, input int bits_per_cycle);
      return xlen / bits_per_cycle;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One single-bit iteration of the muldiv datapath: a shift-add multiply step
// or, when MULDIV_DIV_EN is defined, a restoring divide step.
// Multiply: acc holds {partial product high, remaining multiplier bits}.
// Divide:   acc low half holds the dividend shifting out / quotient shifting
//           in from the LSB; rem holds the running remainder.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
`ifdef MULDIV_DIV_EN
   input  logic              is_div,
   input  logic [XLEN-1:0]   rem_in,
   output logic [XLEN-1:0]   rem_out,
`endif
   input  logic [XLEN-1:0]   operand,
   input  logic [2*XLEN-1:0] acc_in,
   output logic [2*XLEN-1:0] acc_out
);

   logic [XLEN:0] sum;

   // Add the multiplicand into the high half when the current multiplier bit is set.
   always_comb begin
      sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
   end

`ifdef MULDIV_DIV_EN
   logic [XLEN:0]   part;
   logic [XLEN+1:0] diff;
   // After a successful subtract the difference is below the divisor, so
   // bit XLEN of diff is always zero and is never needed.
   logic            unused_diff_msb;

   assign unused_diff_msb = diff[XLEN];

   // Restoring divide step (XLEN+1 bit partial remainder) or shift-add step.
   always_comb begin
      part    = {rem_in, acc_in[XLEN-1]};
      diff    = {1'b0, part} - {2'b00, operand};
      acc_out = {sum, acc_in[XLEN-1:1]};
      rem_out = rem_in;
      if (is_div) begin
         acc_out = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-2:0], ~diff[XLEN+1]};
         rem_out = diff[XLEN+1] ? part[XLEN-1:0] : diff[XLEN-1:0];
      end
   end
`else
   assign acc_out = {sum, acc_in[XLEN-1:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with a start/busy/done handshake.
// Handshake: start_i is accepted in IDLE or DONE (flush_i low); busy_o is high
// for exactly NSTEP cycles of CALC; done_o pulses one cycle with data_o and
// div_by_zero_o valid; data_o holds until the next done_o. flush_i returns to
// IDLE without a done_o. Divide support is compiled in with MULDIV_DIV_EN;
// without it DIVU/REMU complete in one cycle with a zero result.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] data0_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] data_o,
   output logic            div_by_zero_o,
   output state_e          fsm_state
);

   localparam int NSTEP = calc_nstep(XLEN, BITS_PER_CYCLE);
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

   state_e          state;
   state_e          state_next;
   logic [CW-1:0]   cnt;
   op_e             op_q;
   logic [XLEN-1:0] opnd;
   logic [2*XLEN-1:0] acc;
   logic            accept;
   logic            fast;
   logic            last_step;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] fast_result;
   logic            fast_dbz;
   logic [2*XLEN-1:0] acc_chain [BITS_PER_CYCLE+1];

`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] rem_chain [BITS_PER_CYCLE+1];
`endif

   assign accept    = start_i && !flush_i && (state == ST_IDLE || state == ST_DONE);
   assign last_step = (state == ST_CALC) && (cnt == LAST);

   // Decide whether an incoming op bypasses CALC and what it returns.
   always_comb begin
`ifdef MULDIV_DIV_EN
      fast        = op_i[1] && (data1_i == '0);
      fast_result = (op_i == OP_DIVU) ? '1 : data0_i;
      fast_dbz    = 1'b1;
`else
      fast        = op_i[1];
      fast_result = '0;
      fast_dbz    = 1'b0;
`endif
   end

   // Chain of BITS_PER_CYCLE single-bit steps evaluated in one cycle.
   assign acc_chain[0] = acc;
`ifdef MULDIV_DIV_EN
   assign rem_chain[0] = rem;
`endif

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef MULDIV_DIV_EN
         .is_div  (op_q[1]),
         .rem_in  (rem_chain[i]),
         .rem_out (rem_chain[i+1]),
`endif
         .operand (opnd),
         .acc_in  (acc_chain[i]),
         .acc_out (acc_chain[i+1])
      );
   end

   // Select the final result from the last step of the last CALC cycle.
   always_comb begin
      result = '0;
      case (op_q)
         OP_MUL:   result = acc_chain[BITS_PER_CYCLE][XLEN-1:0];
         OP_MULHU: result = acc_chain[BITS_PER_CYCLE][2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
         OP_DIVU:  result = acc_chain[BITS_PER_CYCLE][XLEN-1:0];
         OP_REMU:  result = rem_chain[BITS_PER_CYCLE];
`endif
         default:  result = '0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; flush wins over everything else.
   always_comb begin
      state_next = state;
      if (flush_i) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start_i) state_next = fast ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == LAST) state_next = ST_DONE;
            ST_DONE: begin
               if (start_i) state_next = fast ? ST_DONE : ST_CALC;
               else         state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // FSM outputs decoded from the state register only.
   always_comb begin
      busy_o    = (state == ST_CALC);
      done_o    = (state == ST_DONE);
      fsm_state = state;
   end

   // Operand latch, iteration progress and result registers.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt           <= '0;
         op_q          <= OP_MUL;
         opnd          <= '0;
         acc           <= '0;
`ifdef MULDIV_DIV_EN
         rem           <= '0;
`endif
         data_o        <= '0;
         div_by_zero_o <= 1'b0;
      end else if (accept) begin
         cnt  <= '0;
         op_q <= op_e'(op_i);
         if (op_i[1]) begin
            opnd <= data1_i;
            acc  <= {{XLEN{1'b0}}, data0_i};
         end else begin
            opnd <= data0_i;
            acc  <= {{XLEN{1'b0}}, data1_i};
         end
`ifdef MULDIV_DIV_EN
         rem <= '0;
`endif
         if (fast) begin
            data_o        <= fast_result;
            div_by_zero_o <= fast_dbz;
         end
      end else if (state == ST_CALC && !flush_i) begin
         cnt <= cnt + 1'b1;
         acc <= acc_chain[BITS_PER_CYCLE];
`ifdef MULDIV_DIV_EN
         rem <= rem_chain[BITS_PER_CYCLE];
`endif
         if (last_step) begin
            data_o        <= result;
            div_by_zero_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit (XLEN=32, BITS_PER_CYCLE=1).
// Expected results, flags and completion cycles are queued at issue time and
// checked when done_o pulses.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN  = 32;
   localparam int NSTEP = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            flush;
   logic [1:0]      op_r;
   logic [XLEN-1:0] d0;
   logic [XLEN-1:0] d1;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] dout;
   logic            dbz;
   state_e          fsm_state;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   logic [XLEN-1:0] exp_q[$];
   logic            exp_dbz_q[$];
   int              exp_cyc_q[$];
   logic [XLEN-1:0] last_result = '0;

   // Clock generation.
   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .op_i          (op_r),
      .data0_i       (d0),
      .data1_i       (d1),
      .flush_i       (flush),
      .busy_o        (busy),
      .done_o        (done),
      .data_o        (dout),
      .div_by_zero_o (dbz),
      .fsm_state     (fsm_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Reference model: {div_by_zero, data}.
   function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (op)
         2'b00: return {1'b0, p[31:0]};
         2'b01: return {1'b0, p[63:32]};
`ifdef MULDIV_DIV_EN
         2'b10: return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
         default: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
`else
         default: return 33'd0;
`endif
      endcase
   endfunction

   function automatic int latency(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
      if (op[1] && b == 0) return 1;
      return NSTEP + 1;
`else
      if (op[1]) return 1;
      return NSTEP + 1;
`endif
   endfunction

   // Drive one start pulse (called just after a falling edge) and queue its expectation.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      r     = model(op, a, b);
      op_r  = op;
      d0    = a;
      d1    = b;
      start = 1'b1;
      exp_q.push_back(r[31:0]);
      exp_dbz_q.push_back(r[32]);
      exp_cyc_q.push_back(cyc + latency(op, b));
      step();
      start = 1'b0;
   endtask

   task automatic cancel_last();
      void'(exp_q.pop_back());
      void'(exp_dbz_q.pop_back());
      void'(exp_cyc_q.pop_back());
   endtask

   task automatic drain();
      int budget;
      budget = 200;
      while (exp_q.size() > 0 && budget > 0) begin
         step();
         budget--;
      end
      if (exp_q.size() > 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
         exp_dbz_q.delete();
         exp_cyc_q.delete();
      end
      step();
   endtask

   // Wait (bounded) until done_o is visible in the current cycle.
   task automatic wait_done();
      int budget;
      budget = 100;
      while (done !== 1'b1 && budget > 0) begin
         step();
         budget--;
      end
      if (done !== 1'b1) check("wait_done_timeout", {31'b0, done}, 32'd1);
   endtask

   // Scoreboard: pop and compare on every done_o pulse; flag late completions.
   always @(negedge clk) begin
      logic [31:0] e;
      cyc++;
      if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
         check("done_missing", 32'(cyc), 32'(exp_cyc_q[0]));
         void'(exp_q.pop_front());
         void'(exp_dbz_q.pop_front());
         void'(exp_cyc_q.pop_front());
      end
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", {31'b0, done}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("data", dout, e);
            check("div_by_zero", {31'b0, dbz}, {31'b0, exp_dbz_q.pop_front()});
            check("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            last_result = e;
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  rop;

      rst   = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op_r  = 2'b00;
      d0    = '0;
      d1    = '0;
      repeat (3) step();

      // Reset state.
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_data", dout, 32'd0);
      check("reset_dbz", {31'b0, dbz}, 32'd0);
      check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
      rst = 1'b1;
      step();

      // MUL 7x6 with busy window and an ignored start during CALC.
      start_op(2'b00, 32'd7, 32'd6);
      for (int k = 1; k <= NSTEP; k++) begin
         check("busy_window", {31'b0, busy}, 32'd1);
         if (k == 5) begin
            start = 1'b1;
            op_r  = 2'b01;
            d0    = 32'h1234_5678;
            d1    = 32'h9ABC_DEF0;
         end
         step();
         if (k == 5) start = 1'b0;
      end
      check("busy_fall", {31'b0, busy}, 32'd0);
      check("done_pulse", {31'b0, done}, 32'd1);
      step();
      check("done_one_cycle", {31'b0, done}, 32'd0);
      check("data_hold", dout, 32'd42);

      // MULHU / MUL of all-ones operands.
      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();

      // Back-to-back DIVU then REMU, second started in the DONE cycle.
      start_op(2'b10, 32'd100, 32'd7);
      wait_done();
      start_op(2'b11, 32'd100, 32'd7);
      drain();

      // Back-to-back multiplies.
      start_op(2'b00, 32'd1234, 32'd5678);
      wait_done();
      start_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      drain();

      // Divide by zero fast path; busy never rises.
      start_op(2'b10, 32'd5, 32'd0);
      check("dbz_busy", {31'b0, busy}, 32'd0);
      drain();
      start_op(2'b11, 32'd5, 32'd0);
      check("dbz_busy_rem", {31'b0, busy}, 32'd0);
      drain();

      // Flush at N+10 of a MUL, restart at N+12.
      start_op(2'b00, 32'h0000_DEAD, 32'h0000_BEEF);
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      cancel_last();
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_done", {31'b0, done}, 32'd0);
      check("flush_data", dout, last_result);
      step();
      start_op(2'b00, 32'd300, 32'd301);
      drain();

      // flush_i beats a simultaneous start_i.
      start = 1'b1;
      flush = 1'b1;
      op_r  = 2'b00;
      d0    = 32'd3;
      d1    = 32'd4;
      step();
      start = 1'b0;
      flush = 1'b0;
      check("flush_vs_start_busy", {31'b0, busy}, 32'd0);
      check("flush_vs_start_done", {31'b0, done}, 32'd0);
      step();

      // Reset in the middle of CALC.
      start_op(2'b01, 32'h8000_0001, 32'h7FFF_FFFF);
      repeat (4) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      cancel_last();
      last_result = '0;
      check("midreset_busy", {31'b0, busy}, 32'd0);
      check("midreset_done", {31'b0, done}, 32'd0);
      check("midreset_data", dout, 32'd0);
      check("midreset_dbz", {31'b0, dbz}, 32'd0);
      step();
      start_op(2'b00, 32'd99, 32'd101);
      drain();

      // Random operations, some with a zero divisor.
      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? 32'd0 : (32'($urandom) >> $urandom_range(0, 28));
         start_op(rop, a, b);
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
